d_piso_tx: RTL and testbench
============================

// Module: d_piso_tx
// PURPOSE
//   Parallel-in serial-out transmitter built on the team's D flip-flop style registers.
//   Accepts one WIDTH-bit word through a valid/ready load handshake.
//   Shifts the word out one bit per enabled cycle on sdo, with complement sdo_bar.
//   Transmit end of the serial link; the receive end is a serial-in parallel-out capture register.
// PARAMETERS
//   WIDTH      8  word length in bits; legal range is WIDTH >= 2
//   LSB_FIRST  0  0: bit WIDTH-1 is sent first; 1: bit 0 is sent first
// PORTS
//   clk         in   1      rising-edge clock
//   clr         in   1      synchronous reset, active-high; overrides every other input
//   din         in   WIDTH  parallel word to transmit
//   load_valid  in   1      din is valid this cycle
//   load_ready  out  1      high only in IDLE; a load occurs when load_valid && load_ready at posedge clk
//   shift_en    in   1      bit-rate enable; advances the serial stream only in SHIFT
//   sdo         out  1      serial data, registered
//   sdo_bar     out  1      always ~sdo
//   frame       out  1      high while a word's bits are on sdo
//   done        out  1      one-cycle pulse after the last bit has been held
// BEHAVIOUR
//   Reset: clr=1 at posedge clk gives:
//     - state IDLE; shreg=0; count=0
//     - sdo=0, sdo_bar=1, frame=0, done=0, load_ready=1
//     - clr has priority over load and shift in every state, including mid-frame.
//   States: IDLE, SHIFT. load_ready = (state==IDLE), decoded from registered state only.
//   IDLE:
//     - shift_en is ignored.
//     - Load edge (load_valid=1): shreg<=din; count<=WIDTH-1; sdo<=first bit (din[WIDTH-1], or din[0] if LSB_FIRST); frame<=1; state<=SHIFT.
//     - done<=0 on every IDLE edge that does not also load.
//   SHIFT:
//     - Edge with shift_en=0: sdo, shreg, count, frame and state all hold. Each bit stays on sdo for >=1 cycle.
//     - Edge with shift_en=1 and count!=0: shift shreg toward the output end; sdo<=next bit; count<=count-1.
//     - Edge with shift_en=1 and count==0: sdo<=0; frame<=0; done<=1; state<=IDLE.
//     - load_valid is ignored (load_ready=0); din changes have no effect on the word in flight.
//   Latency: first bit appears on sdo the cycle after the load edge. With shift_en held high, frame stays high exactly WIDTH cycles, and done is high in the cycle after frame falls.
//   Back-to-back: load_ready=1 in the same cycle done=1, so a load at that edge starts the next frame with no idle gap beyond the done cycle.
//   count width is $clog2(WIDTH); it never wraps below 0; unused shreg bits are don't-care.
//   sdo_bar is combinational ~sdo, so it is never equal to sdo.
// TESTING
//   1. clr=1 for 2 cycles with random inputs -> sdo=0, sdo_bar=1, frame=0, done=0, load_ready=1.
//   2. WIDTH=8, MSB first, load din=8'hA5, shift_en=1 -> sdo=1,0,1,0,0,1,0,1 on successive cycles; frame high 8 cycles; done pulses once on the next cycle.
//   3. din=8'hA5, shift_en high on alternate cycles -> each bit held 2 cycles; frame high 16 cycles; same bit order.
//   4. Mid-frame, load_valid=1 with din=8'hFF -> load_ready=0, the load is ignored, and the 8'hA5 stream completes unchanged.
//   5. LSB_FIRST=1, din=8'h01 -> sdo=1 then seven 0s. Then load 8'h80 in the done cycle -> the next frame starts immediately: seven 0s then 1.
//   6. clr=1 after the 3rd bit of 8'hC3 -> next cycle shows reset values; a new load of 8'h3C then transmits correctly.

Source files
------------

// File: rtl/d_piso_tx.sv
// Parallel-in serial-out transmitter: valid/ready word load, one bit per shift_en cycle on sdo.
// First bit is registered the cycle after the load edge; done pulses once after the last bit.
module d_piso_tx #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             sdo,
  output logic             sdo_bar,
  output logic             frame,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    count;

  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
      shreg <= '0;
      count <= '0;
      sdo   <= 1'b0;
      frame <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // done is cleared on a load edge as well so it stays a single-cycle pulse
          done <= 1'b0;
          if (load_valid) begin
            shreg <= din;
            count <= LAST;
            sdo   <= LSB_FIRST ? din[0] : din[WIDTH-1];
            frame <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (shift_en) begin
            if (count != '0) begin
              shreg <= LSB_FIRST ? (shreg >> 1) : (shreg << 1);
              sdo   <= LSB_FIRST ? shreg[1] : shreg[WIDTH-2];
              count <= count - CW'(1);
            end else begin
              sdo   <= 1'b0;
              frame <= 1'b0;
              done  <= 1'b1;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign load_ready = (state == IDLE);
  assign sdo_bar    = ~sdo;

endmodule

// File: tb/tb_d_piso_tx.sv
// Bench for d_piso_tx: an MSB-first and an LSB-first instance checked against a bit-index reference model.
module tb_d_piso_tx;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       clr[2], load_valid[2], load_ready[2], shift_en[2];
  logic       sdo[2], sdo_bar[2], frame[2], done[2];
  logic [7:0] din[2];

  int ncmp  = 0;
  int nfail = 0;

  // reference model: which word is in flight and which bit index of it is on sdo
  bit         busy[2];
  bit         mdone[2];
  logic [7:0] mword[2];
  int         midx[2];

  d_piso_tx #(.WIDTH(8), .LSB_FIRST(1'b0)) dut_msb (
    .clk(clk), .clr(clr[0]), .din(din[0]), .load_valid(load_valid[0]),
    .load_ready(load_ready[0]), .shift_en(shift_en[0]), .sdo(sdo[0]),
    .sdo_bar(sdo_bar[0]), .frame(frame[0]), .done(done[0]));

  d_piso_tx #(.WIDTH(8), .LSB_FIRST(1'b1)) dut_lsb (
    .clk(clk), .clr(clr[1]), .din(din[1]), .load_valid(load_valid[1]),
    .load_ready(load_ready[1]), .shift_en(shift_en[1]), .sdo(sdo[1]),
    .sdo_bar(sdo_bar[1]), .frame(frame[1]), .done(done[1]));

  function automatic logic exp_sdo(int d);
    logic [7:0] w;
    if (!busy[d]) return 1'b0;
    w = mword[d];
    return (d == 1) ? w[midx[d]] : w[7 - midx[d]];
  endfunction

  function automatic void model_step(int d);
    if (clr[d] === 1'b1) begin
      busy[d] = 0; mdone[d] = 0; midx[d] = 0;
    end else if (!busy[d]) begin
      mdone[d] = 0;
      if (load_valid[d] === 1'b1) begin
        busy[d] = 1; mword[d] = din[d]; midx[d] = 0;
      end
    end else begin
      mdone[d] = 0;
      if (shift_en[d] === 1'b1) begin
        if (midx[d] == 7) begin
          busy[d] = 0; mdone[d] = 1;
        end else begin
          midx[d] = midx[d] + 1;
        end
      end
    end
  endfunction

  task automatic clock_edge();
    for (int d = 0; d < 2; d++) model_step(d);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      for (int d = 0; d < 2; d++) begin
        clr[d] = 1'b1; din[d] = 8'($urandom);
        load_valid[d] = 1'($urandom); shift_en[d] = 1'($urandom);
      end
      clock_edge();
      for (int d = 0; d < 2; d++) begin
        ncmp++;
        if ({sdo[d], sdo_bar[d], frame[d], done[d], load_ready[d]} !== 5'b01001) begin
          nfail++;
          $display("FAIL reset c=%0d d=%0d got sdo,bar,frame,done,rdy=%b exp=01001", c, d,
                   {sdo[d], sdo_bar[d], frame[d], done[d], load_ready[d]});
        end
      end
    end
    for (int d = 0; d < 2; d++) begin
      clr[d] = 1'b0; load_valid[d] = 1'b0; shift_en[d] = 1'b0;
    end
  endtask

  task automatic test_msb_a5();
    int frames = 0, dones = 0;
    logic [7:0] w = '0;
    din[0] = 8'hA5; load_valid[0] = 1'b1; shift_en[0] = 1'b1;
    for (int c = 0; c < 11; c++) begin
      clock_edge();
      load_valid[0] = 1'b0; din[0] = 8'($urandom);
      ncmp++;
      if ({sdo[0], sdo_bar[0], frame[0], done[0], load_ready[0]} !==
          {exp_sdo(0), ~exp_sdo(0), busy[0], mdone[0], ~busy[0]}) begin
        nfail++;
        $display("FAIL msb_a5 c=%0d got=%b exp=%b", c,
                 {sdo[0], sdo_bar[0], frame[0], done[0], load_ready[0]},
                 {exp_sdo(0), ~exp_sdo(0), busy[0], mdone[0], ~busy[0]});
      end
      if (frame[0] === 1'b1) begin frames++; w = {w[6:0], sdo[0]}; end
      if (done[0] === 1'b1) dones++;
    end
    ncmp++;
    if (frames != 8 || dones != 1 || w !== 8'hA5) begin
      nfail++;
      $display("FAIL msb_a5_frame got frames=%0d dones=%0d word=%h exp 8/1/a5", frames, dones, w);
    end
  endtask

  task automatic test_alternate();
    int frames = 0, dones = 0;
    logic [7:0] w = '0;
    din[0] = 8'hA5; load_valid[0] = 1'b1;
    for (int c = 0; c < 19; c++) begin
      clock_edge();
      load_valid[0] = 1'b0;
      shift_en[0] = (c % 2 == 1);
      ncmp++;
      if ({sdo[0], sdo_bar[0], frame[0], done[0], load_ready[0]} !==
          {exp_sdo(0), ~exp_sdo(0), busy[0], mdone[0], ~busy[0]}) begin
        nfail++;
        $display("FAIL alternate c=%0d got=%b exp=%b", c,
                 {sdo[0], sdo_bar[0], frame[0], done[0], load_ready[0]},
                 {exp_sdo(0), ~exp_sdo(0), busy[0], mdone[0], ~busy[0]});
      end
      if (frame[0] === 1'b1) begin
        frames++;
        if (c % 2 == 0) w = {w[6:0], sdo[0]};
      end
      if (done[0] === 1'b1) dones++;
    end
    shift_en[0] = 1'b0;
    ncmp++;
    if (frames != 16 || dones != 1 || w !== 8'hA5) begin
      nfail++;
      $display("FAIL alternate_frame got frames=%0d dones=%0d word=%h exp 16/1/a5", frames, dones, w);
    end
  endtask

  task automatic test_ignore_load();
    logic [7:0] w = '0;
    din[0] = 8'hA5; load_valid[0] = 1'b1; shift_en[0] = 1'b1;
    for (int c = 0; c < 11; c++) begin
      clock_edge();
      load_valid[0] = (c >= 2 && c <= 5);
      din[0] = 8'hFF;
      ncmp++;
      if ({sdo[0], sdo_bar[0], frame[0], done[0], load_ready[0]} !==
          {exp_sdo(0), ~exp_sdo(0), busy[0], mdone[0], ~busy[0]}) begin
        nfail++;
        $display("FAIL ignore_load c=%0d got=%b exp=%b", c,
                 {sdo[0], sdo_bar[0], frame[0], done[0], load_ready[0]},
                 {exp_sdo(0), ~exp_sdo(0), busy[0], mdone[0], ~busy[0]});
      end
      if (frame[0] === 1'b1) w = {w[6:0], sdo[0]};
    end
    load_valid[0] = 1'b0;
    ncmp++;
    if (w !== 8'hA5) begin
      nfail++;
      $display("FAIL ignore_load_word got=%h exp=a5", w);
    end
  endtask

  task automatic test_lsb_back_to_back();
    int frames = 0, dones = 0, nload = 0;
    logic [7:0] w0 = '0, w1 = '0;
    din[1] = 8'h01; load_valid[1] = 1'b1; shift_en[1] = 1'b1;
    for (int c = 0; c < 19; c++) begin
      clock_edge();
      load_valid[1] = 1'b0;
      ncmp++;
      if ({sdo[1], sdo_bar[1], frame[1], done[1], load_ready[1]} !==
          {exp_sdo(1), ~exp_sdo(1), busy[1], mdone[1], ~busy[1]}) begin
        nfail++;
        $display("FAIL lsb_b2b c=%0d got=%b exp=%b", c,
                 {sdo[1], sdo_bar[1], frame[1], done[1], load_ready[1]},
                 {exp_sdo(1), ~exp_sdo(1), busy[1], mdone[1], ~busy[1]});
      end
      if (frame[1] === 1'b1) begin
        frames++;
        if (nload == 0) w0 = {sdo[1], w0[7:1]};
        else            w1 = {sdo[1], w1[7:1]};
      end
      if (done[1] === 1'b1) dones++;
      if (mdone[1] && nload == 0) begin
        load_valid[1] = 1'b1; din[1] = 8'h80; nload = 1;
      end
    end
    shift_en[1] = 1'b0;
    ncmp++;
    if (frames != 16 || dones != 2 || w0 !== 8'h01 || w1 !== 8'h80) begin
      nfail++;
      $display("FAIL lsb_b2b_words got frames=%0d dones=%0d w0=%h w1=%h exp 16/2/01/80",
               frames, dones, w0, w1);
    end
  endtask

  task automatic test_clr_mid();
    logic [7:0] w = '0;
    din[0] = 8'hC3; load_valid[0] = 1'b1; shift_en[0] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      clock_edge();
      load_valid[0] = 1'b0;
      ncmp++;
      if ({sdo[0], sdo_bar[0], frame[0], done[0], load_ready[0]} !==
          {exp_sdo(0), ~exp_sdo(0), busy[0], mdone[0], ~busy[0]}) begin
        nfail++;
        $display("FAIL clr_mid_pre c=%0d got=%b exp=%b", c,
                 {sdo[0], sdo_bar[0], frame[0], done[0], load_ready[0]},
                 {exp_sdo(0), ~exp_sdo(0), busy[0], mdone[0], ~busy[0]});
      end
    end
    clr[0] = 1'b1; load_valid[0] = 1'b1; din[0] = 8'hFF;
    clock_edge();
    ncmp++;
    if ({sdo[0], sdo_bar[0], frame[0], done[0], load_ready[0]} !== 5'b01001) begin
      nfail++;
      $display("FAIL clr_mid_reset got=%b exp=01001",
               {sdo[0], sdo_bar[0], frame[0], done[0], load_ready[0]});
    end
    clr[0] = 1'b0; din[0] = 8'h3C; load_valid[0] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      clock_edge();
      load_valid[0] = 1'b0;
      ncmp++;
      if ({sdo[0], sdo_bar[0], frame[0], done[0], load_ready[0]} !==
          {exp_sdo(0), ~exp_sdo(0), busy[0], mdone[0], ~busy[0]}) begin
        nfail++;
        $display("FAIL clr_mid_post c=%0d got=%b exp=%b", c,
                 {sdo[0], sdo_bar[0], frame[0], done[0], load_ready[0]},
                 {exp_sdo(0), ~exp_sdo(0), busy[0], mdone[0], ~busy[0]});
      end
      if (frame[0] === 1'b1) w = {w[6:0], sdo[0]};
    end
    ncmp++;
    if (w !== 8'h3C) begin
      nfail++;
      $display("FAIL clr_mid_word got=%h exp=3c", w);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int d = 0; d < 2; d++) begin
        clr[d]        = ($urandom_range(0, 39) == 0);
        din[d]        = 8'($urandom);
        load_valid[d] = 1'($urandom);
        shift_en[d]   = ($urandom_range(0, 3) != 0);
      end
      clock_edge();
      for (int d = 0; d < 2; d++) begin
        ncmp++;
        if ({sdo[d], sdo_bar[d], frame[d], done[d], load_ready[d]} !==
            {exp_sdo(d), ~exp_sdo(d), busy[d], mdone[d], ~busy[d]}) begin
          nfail++;
          $display("FAIL random c=%0d d=%0d got=%b exp=%b", c, d,
                   {sdo[d], sdo_bar[d], frame[d], done[d], load_ready[d]},
                   {exp_sdo(d), ~exp_sdo(d), busy[d], mdone[d], ~busy[d]});
        end
      end
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      clr[d] = 1'b1; din[d] = '0; load_valid[d] = 1'b0; shift_en[d] = 1'b0;
      busy[d] = 0; mdone[d] = 0; mword[d] = '0; midx[d] = 0;
    end
    test_reset();
    test_msb_a5();
    test_alternate();
    test_ignore_load();
    test_lsb_back_to_back();
    test_clr_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
